// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter: shares one ALU between two valid/ready requesters with round-robin grants.
// Define ALU_PERF_EN to add the op_cnt / req_wait performance counters.

module alu_core #(
  parameter int WIDTH = 6
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       f,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    case (f)
      3'b000:  y = a + b;
      3'b001:  y = a - b;
      3'b010:  y = a & b;
      3'b011:  y = a | b;
      3'b100:  y = a ^ b;
      default: y = '0;
    endcase
  end

endmodule

module alu_rr_arbiter #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_f,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic [WIDTH-1:0] resp0_y,
  output logic             resp0_z,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_f,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [WIDTH-1:0] resp1_y,
  output logic             resp1_z,
  output logic             busy
`ifdef ALU_PERF_EN
  ,
  output logic [15:0]      op_cnt,
  output logic [15:0]      req_wait
`endif
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state;
  logic             last_grant;
  logic             gnt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [2:0]       f_q;
  logic [WIDTH-1:0] alu_y;
  logic             acc0;
  logic             acc1;
  logic             resp_hs;

  // Ready is gated by rst_n so it reads 0 while reset is held, even with valid high.
  assign req0_ready = rst_n && (state == IDLE) && req0_valid && (!req1_valid || last_grant);
  assign req1_ready = rst_n && (state == IDLE) && req1_valid && (!req0_valid || !last_grant);
  assign acc0       = req0_valid && req0_ready;
  assign acc1       = req1_valid && req1_ready;
  assign resp_hs    = (state == RESP) && (gnt ? resp1_ready : resp0_ready);
  assign busy       = (state != IDLE);

  alu_core #(.WIDTH(WIDTH)) u_alu (
    .a (a_q),
    .b (b_q),
    .f (f_q),
    .y (alu_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      gnt         <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      f_q         <= '0;
      resp0_valid <= 1'b0;
      resp1_valid <= 1'b0;
      resp0_y     <= '0;
      resp1_y     <= '0;
      resp0_z     <= 1'b0;
      resp1_z     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (acc0 || acc1) begin
            a_q        <= acc1 ? req1_a : req0_a;
            b_q        <= acc1 ? req1_b : req0_b;
            f_q        <= acc1 ? req1_f : req0_f;
            gnt        <= acc1;
            last_grant <= acc1;
            state      <= EXEC;
          end
        end
        EXEC: begin
          // Only the owner's result registers change; the other side keeps its last result.
          if (gnt) begin
            resp1_y     <= alu_y;
            resp1_z     <= (alu_y == '0);
            resp1_valid <= 1'b1;
          end else begin
            resp0_y     <= alu_y;
            resp0_z     <= (alu_y == '0);
            resp0_valid <= 1'b1;
          end
          state <= RESP;
        end
        RESP: begin
          if (resp_hs) begin
            resp0_valid <= 1'b0;
            resp1_valid <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_cnt   <= '0;
      req_wait <= '0;
    end else begin
      if (resp_hs)
        op_cnt <= op_cnt + 16'd1;
      if ((req0_valid || req1_valid) && !(acc0 || acc1) && (req_wait != 16'hFFFF))
        req_wait <= req_wait + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// tb_alu_rr_arbiter: directed plus randomized checks of alu_rr_arbiter against a queue-based model.
// Build with ALU_PERF_EN defined to also check op_cnt / req_wait.

module tb_alu_rr_arbiter;

  localparam int WIDTH = 6;
  localparam int MOD   = 64;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req0_valid = 1'b0, req1_valid = 1'b0;
  logic             req0_ready, req1_ready;
  logic [WIDTH-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [2:0]       req0_f = '0, req1_f = '0;
  logic             resp0_valid, resp1_valid;
  logic             resp0_ready = 1'b0, resp1_ready = 1'b0;
  logic [WIDTH-1:0] resp0_y, resp1_y;
  logic             resp0_z, resp1_z;
  logic             busy;
`ifdef ALU_PERF_EN
  logic [15:0]      op_cnt, req_wait;
`endif

  alu_rr_arbiter #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_a      (req0_a),
    .req0_b      (req0_b),
    .req0_f      (req0_f),
    .resp0_valid (resp0_valid),
    .resp0_ready (resp0_ready),
    .resp0_y     (resp0_y),
    .resp0_z     (resp0_z),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_a      (req1_a),
    .req1_b      (req1_b),
    .req1_f      (req1_f),
    .resp1_valid (resp1_valid),
    .resp1_ready (resp1_ready),
    .resp1_y     (resp1_y),
    .resp1_z     (resp1_z),
    .busy        (busy)
`ifdef ALU_PERF_EN
    ,
    .op_cnt      (op_cnt),
    .req_wait    (req_wait)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int a;
    int b;
    int f;
  } op_t;

  op_t q0[$];
  op_t q1[$];
  int  checks = 0;
  int  failures = 0;
  int  lastGrant = 1;
  int  opCntExp = 0;
  int  reqWaitExp = 0;

  function automatic int modelY(op_t op);
    case (op.f)
      0:       return (op.a + op.b) % MOD;
      1:       return (op.a - op.b + MOD) % MOD;
      2:       return op.a & op.b;
      3:       return op.a | op.b;
      4:       return op.a ^ op.b;
      default: return 0;
    endcase
  endfunction

  function automatic op_t mkOp(int a, int b, int f);
    op_t o;
    o.a = a;
    o.b = b;
    o.f = f;
    return o;
  endfunction

  function automatic op_t randOp();
    return mkOp(int'($urandom_range(0, MOD - 1)), int'($urandom_range(0, MOD - 1)),
                int'($urandom_range(0, 7)));
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Present the head of each requester's queue; an empty queue drops valid.
  task automatic applyStimulus();
    req0_valid = (q0.size() > 0);
    if (q0.size() > 0) begin
      req0_a = WIDTH'(q0[0].a);
      req0_b = WIDTH'(q0[0].b);
      req0_f = 3'(q0[0].f);
    end
    req1_valid = (q1.size() > 0);
    if (q1.size() > 0) begin
      req1_a = WIDTH'(q1[0].a);
      req1_b = WIDTH'(q1[0].b);
      req1_f = 3'(q1[0].f);
    end
  endtask

  task automatic checkCounters(input string tag);
`ifdef ALU_PERF_EN
    checkOutput({tag, "_op_cnt"}, {16'd0, op_cnt}, opCntExp);
    checkOutput({tag, "_req_wait"}, {16'd0, req_wait}, reqWaitExp);
`endif
  endtask

  task automatic doReset();
    rst_n       = 1'b0;
    req0_valid  = 1'b1;
    req1_valid  = 1'b1;
    resp0_ready = 1'b0;
    resp1_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_ready0", req0_ready, 0);
    checkOutput("rst_ready1", req1_ready, 0);
    checkOutput("rst_resp0_valid", resp0_valid, 0);
    checkOutput("rst_resp1_valid", resp1_valid, 0);
    checkOutput("rst_resp0_y", resp0_y, 0);
    checkOutput("rst_resp1_y", resp1_y, 0);
    checkOutput("rst_resp0_z", resp0_z, 0);
    checkOutput("rst_resp1_z", resp1_z, 0);
    checkOutput("rst_busy", busy, 0);
    q0.delete();
    q1.delete();
    lastGrant  = 1;
    opCntExp   = 0;
    reqWaitExp = 0;
    checkCounters("rst");
    applyStimulus();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One full transaction: arbitration, EXEC, RESP held for `stall` extra cycles, handshake.
  task automatic serveOne(input int stall, output int win);
    op_t op;
    int  y, z, anyV;
    applyStimulus();
    #1;
    if (req0_valid && !req1_valid) win = 0;
    else if (req1_valid && !req0_valid) win = 1;
    else win = 1 - lastGrant;
    checkOutput("arb_ready0", req0_ready, (win == 0) ? 1 : 0);
    checkOutput("arb_ready1", req1_ready, (win == 1) ? 1 : 0);
    @(posedge clk);
    lastGrant = win;
    if (win == 0) op = q0.pop_front();
    else op = q1.pop_front();
    y = modelY(op);
    z = (y == 0) ? 1 : 0;
    @(negedge clk);
    applyStimulus();
    anyV = (req0_valid || req1_valid) ? 1 : 0;
    #1;
    checkOutput("exec_busy", busy, 1);
    checkOutput("exec_resp0_valid", resp0_valid, 0);
    checkOutput("exec_resp1_valid", resp1_valid, 0);
    checkOutput("exec_ready", req0_ready | req1_ready, 0);
    @(negedge clk);
    #1;
    for (int i = 0; i <= stall; i++) begin
      if (i > 0) begin
        @(negedge clk);
        #1;
      end
      checkOutput("resp_valid0", resp0_valid, (win == 0) ? 1 : 0);
      checkOutput("resp_valid1", resp1_valid, (win == 1) ? 1 : 0);
      checkOutput("resp_y", (win == 1) ? resp1_y : resp0_y, y);
      checkOutput("resp_z", (win == 1) ? resp1_z : resp0_z, z);
      checkOutput("resp_busy", busy, 1);
      checkOutput("resp_ready", req0_ready | req1_ready, 0);
    end
    if (win == 0) resp0_ready = 1'b1;
    else resp1_ready = 1'b1;
    @(posedge clk);
    opCntExp   = (opCntExp + 1) % 65536;
    reqWaitExp = reqWaitExp + anyV * (2 + stall);
    if (reqWaitExp > 65535) reqWaitExp = 65535;
    @(negedge clk);
    resp0_ready = 1'b0;
    resp1_ready = 1'b0;
    #1;
    checkOutput("done_resp0_valid", resp0_valid, 0);
    checkOutput("done_resp1_valid", resp1_valid, 0);
    checkOutput("done_busy", busy, 0);
    checkOutput("hold_y", (win == 1) ? resp1_y : resp0_y, y);
    checkOutput("hold_z", (win == 1) ? resp1_z : resp0_z, z);
    checkCounters("done");
  endtask

  initial begin
    int win;
    int order[6];
    order = '{0, 1, 0, 1, 0, 1};

    doReset();

    // Single add on requester 0.
    q0.push_back(mkOp(5, 3, 0));
    serveOne(0, win);
    checkOutput("t1_y_const", resp0_y, 8);

    // Subtraction to zero and with wrap-around on requester 1.
    q1.push_back(mkOp(3, 3, 1));
    q1.push_back(mkOp(2, 5, 1));
    serveOne(0, win);
    checkOutput("t2_zero_z", resp1_z, 1);
    serveOne(1, win);
    checkOutput("t2_wrap_y", resp1_y, 61);

    // Both requesters busy from reset: strict alternation starting with req0.
    doReset();
    for (int i = 0; i < 3; i++) begin
      q0.push_back(randOp());
      q1.push_back(randOp());
    end
    for (int i = 0; i < 6; i++) begin
      serveOne(0, win);
      checkOutput("t3_order", win, order[i]);
    end

    // Stalled response on req0 blocks req1 until released.
    q0.push_back(randOp());
    q1.push_back(randOp());
    serveOne(4, win);
    checkOutput("t4_first", win, 0);
    serveOne(0, win);
    checkOutput("t4_second", win, 1);

    // Reset during EXEC discards the op; a tie afterwards goes to req0.
    q0.push_back(mkOp(7, 7, 0));
    applyStimulus();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("t5_busy", busy, 0);
    checkOutput("t5_resp0_valid", resp0_valid, 0);
    checkOutput("t5_resp1_valid", resp1_valid, 0);
    checkOutput("t5_resp0_y", resp0_y, 0);
    checkOutput("t5_resp1_y", resp1_y, 0);
    checkOutput("t5_ready0", req0_ready, 0);
    q0.delete();
    q1.delete();
    lastGrant  = 1;
    opCntExp   = 0;
    reqWaitExp = 0;
    applyStimulus();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("t5_no_resp0", resp0_valid, 0);
    checkOutput("t5_no_resp1", resp1_valid, 0);
    checkCounters("t5");
    q0.push_back(randOp());
    q1.push_back(randOp());
    serveOne(0, win);
    checkOutput("t5_tie", win, 0);
    serveOne(0, win);

    // Undefined opcode yields zero.
    q1.push_back(mkOp(9, 9, 7));
    serveOne(0, win);
    checkOutput("t6_y", resp1_y, 0);
    checkOutput("t6_z", resp1_z, 1);

    // Randomized mix of single and tied requests with random response stalls.
    for (int n = 0; n < 20; n++) begin
      int pick;
      pick = int'($urandom_range(1, 3));
      if (pick != 2) q0.push_back(randOp());
      if (pick != 1) q1.push_back(randOp());
      while (q0.size() > 0 || q1.size() > 0)
        serveOne(int'($urandom_range(0, 2)), win);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
